// File: rtl/exe_pkg.sv
// Shared encodings for the EXE stage:
// operand selects, ALU ops, mul/div ops and FSM states.
package exe_pkg;

  localparam int A_SEL_WIDTH  = 3;
  localparam int B_SEL_WIDTH  = 3;
  localparam int ALU_OP_WIDTH = 4;

  localparam logic [A_SEL_WIDTH-1:0] A_SEL_RS1  = 3'd0;
  localparam logic [A_SEL_WIDTH-1:0] A_SEL_PC   = 3'd1;
  localparam logic [A_SEL_WIDTH-1:0] A_SEL_ALU  = 3'd2;
  localparam logic [A_SEL_WIDTH-1:0] A_SEL_MEM  = 3'd3;
  localparam logic [A_SEL_WIDTH-1:0] A_SEL_ZERO = 3'd4;

  localparam logic [B_SEL_WIDTH-1:0] B_SEL_RS2  = 3'd0;
  localparam logic [B_SEL_WIDTH-1:0] B_SEL_IMM  = 3'd1;
  localparam logic [B_SEL_WIDTH-1:0] B_SEL_FOUR = 3'd2;
  localparam logic [B_SEL_WIDTH-1:0] B_SEL_ALU  = 3'd3;
  localparam logic [B_SEL_WIDTH-1:0] B_SEL_MEM  = 3'd4;
  localparam logic [B_SEL_WIDTH-1:0] B_SEL_ZERO = 3'd5;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD    = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB    = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL    = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT    = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU   = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR    = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL    = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA    = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR     = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND    = 4'd9;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_PASS_B = 4'd10;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/execute_md_stage_alu.sv
// Single-cycle integer ALU for the EXE stage.
// Shifts use the low log2(XLEN) bits of b.
module alu
  import exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [ALU_OP_WIDTH-1:0] op,
  input  logic [XLEN-1:0]         a,
  input  logic [XLEN-1:0]         b,
  output logic [XLEN-1:0]         y
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  logic            lt_s;
  logic            lt_u;

  assign shamt = b[SH_W-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  // Operation select
  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << shamt;
      ALU_SLT:    y = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU:   y = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> shamt;
      ALU_SRA:    y = $signed(a) >>> shamt;
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_PASS_B: y = b;
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/execute_md_stage_muldiv.sv
// Iterative RV M-extension unit: one bit per cycle,
// shift-add multiply and restoring divide on magnitudes.
module muldiv_iter
  import exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  input  logic            hold,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  md_state_e       state_q;
  md_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  md_op_e          op_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] a_q;
  logic            neg_q;
  logic            rneg_q;
  logic            dz_q;

  logic            a_sgn;
  logic            b_sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            load;

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shf;
  logic            ge;
  logic [XLEN-1:0] sub;

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  assign busy = state_q == BUSY;
  assign done = state_q == DONE;
  assign load = (state_q == IDLE) & start & ~kill;

  // Operand signedness and magnitudes at capture
  always_comb begin
    a_sgn = op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    b_sgn = op inside {MD_MULH, MD_DIV, MD_REM};
    a_neg = a_sgn & a[XLEN-1];
    b_neg = b_sgn & b[XLEN-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
  end

  // One iteration of shift-add and of restoring divide
  always_comb begin
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    shf = {hi_q, lo_q[XLEN-1]};
    ge  = shf >= {1'b0, dvs_q};
    sub = shf[XLEN-1:0] - dvs_q;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = BUSY;
      BUSY: if (cnt_q == CNT_W'(XLEN-1)) state_d = DONE;
      DONE: if (!hold) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      op_q   <= MD_MUL;
      hi_q   <= '0;
      lo_q   <= '0;
      dvs_q  <= '0;
      a_q    <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else if (load) begin
      cnt_q  <= '0;
      op_q   <= op;
      hi_q   <= '0;
      lo_q   <= a_mag;
      dvs_q  <= b_mag;
      a_q    <= a;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      dz_q   <= b == '0;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + 1'b1;
      if (op_q[2]) begin
        if (ge) begin
          hi_q <= sub;
          lo_q <= {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_q <= shf[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_q <= sum[XLEN:1];
        lo_q <= {sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  // Sign fix-up and special cases
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? (~prod + 1'b1) : prod;
    quo    = neg_q ? (~lo_q + 1'b1) : lo_q;
    rem    = rneg_q ? (~hi_q + 1'b1) : hi_q;
    result = '0;
    unique case (op_q)
      MD_MUL:    result = prod_s[XLEN-1:0];
      MD_MULH,
      MD_MULHSU,
      MD_MULHU:  result = prod_s[2*XLEN-1:XLEN];
      MD_DIV,
      MD_DIVU:   result = dz_q ? '1 : quo;
      MD_REM,
      MD_REMU:   result = dz_q ? a_q : rem;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/execute_md_stage.sv
// EXE stage: operand muxes, ALU, iterative mul/div
// and the EXE/MEM pipeline registers.
module execute_md_stage
  import exe_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_exe,
  input  logic                      stall_in,
  input  logic                      flush,
  input  logic [XLEN-1:0]           pc_exe,
  input  logic [XLEN-1:0]           rs1_exe,
  input  logic [XLEN-1:0]           rs2_exe,
  input  logic [XLEN-1:0]           instr_exe,
  input  logic [XLEN-1:0]           imm_exe,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_exe,
  input  logic [A_SEL_WIDTH-1:0]    a_sel,
  input  logic [B_SEL_WIDTH-1:0]    b_sel,
  input  logic [ALU_OP_WIDTH-1:0]   alu_op,
  input  logic                      md_en,
  input  logic [2:0]                md_op,
  input  logic [XLEN-1:0]           forward_mem,
  input  logic [XLEN-1:0]           forward_wb,
  output logic                      busy_exe,
  output logic                      valid_mem,
  output logic [XLEN-1:0]           pc_mem,
  output logic [XLEN-1:0]           alu_mem,
  output logic [XLEN-1:0]           rs2_mem,
  output logic [XLEN-1:0]           instr_mem,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_mem
);

  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_y;
  logic [XLEN-1:0] md_res;
  logic            md_busy;
  logic            md_done;
  logic            accept;
  logic            sel_bub;
  logic            sel_md;
  logic            sel_alu;

  // ALU A operand source
  always_comb begin
    alu_a = '0;
    unique case (a_sel)
      A_SEL_RS1:  alu_a = rs1_exe;
      A_SEL_PC:   alu_a = pc_exe;
      A_SEL_ALU:  alu_a = forward_mem;
      A_SEL_MEM:  alu_a = forward_wb;
      A_SEL_ZERO: alu_a = '0;
      default:    alu_a = '0;
    endcase
  end

  // ALU B operand source
  always_comb begin
    alu_b = '0;
    unique case (b_sel)
      B_SEL_RS2:  alu_b = rs2_exe;
      B_SEL_IMM:  alu_b = imm_exe;
      B_SEL_FOUR: alu_b = XLEN'(4);
      B_SEL_ALU:  alu_b = forward_mem;
      B_SEL_MEM:  alu_b = forward_wb;
      B_SEL_ZERO: alu_b = '0;
      default:    alu_b = '0;
    endcase
  end

  alu #(
    .XLEN (XLEN)
  ) u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  // A new mul/div may only start from an idle unit;
  // reset also masks it so busy drops at once.
  assign accept = ~rst & valid_exe & md_en & ~flush
                & ~md_busy & ~md_done;

  assign busy_exe = accept | md_busy | (md_done & stall_in);

  muldiv_iter #(
    .XLEN (XLEN)
  ) u_md (
    .clk    (clk),
    .rst    (rst),
    .start  (accept),
    .op     (md_op_e'(md_op)),
    .a      (alu_a),
    .b      (alu_b),
    .kill   (flush),
    .hold   (stall_in),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_res)
  );

  // What the EXE/MEM registers take on an advance
  always_comb begin
    sel_bub = flush | accept | md_busy;
    sel_md  = ~flush & md_done;
    sel_alu = ~sel_bub & ~sel_md;
  end

  // EXE/MEM pipeline registers; bubbles are all-zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_mem   <= 1'b0;
      pc_mem      <= '0;
      alu_mem     <= '0;
      rs2_mem     <= '0;
      instr_mem   <= '0;
      rd_addr_mem <= '0;
    end else if (!stall_in) begin
      unique case (1'b1)
        sel_bub: begin
          valid_mem   <= 1'b0;
          pc_mem      <= '0;
          alu_mem     <= '0;
          rs2_mem     <= '0;
          instr_mem   <= '0;
          rd_addr_mem <= '0;
        end
        sel_md: begin
          valid_mem   <= 1'b1;
          pc_mem      <= pc_exe;
          alu_mem     <= md_res;
          rs2_mem     <= rs2_exe;
          instr_mem   <= instr_exe;
          rd_addr_mem <= rd_addr_exe;
        end
        sel_alu: begin
          valid_mem   <= valid_exe;
          pc_mem      <= pc_exe;
          alu_mem     <= alu_y;
          rs2_mem     <= rs2_exe;
          instr_mem   <= instr_exe;
          rd_addr_mem <= rd_addr_exe;
        end
        default: begin
          valid_mem <= 1'b0;
        end
      endcase
    end
  end

endmodule
